// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - shared screen encoding and widths for the poker VGA display
package poker_pkg;

    typedef enum logic [1:0] {
        SCR_TITLE  = 2'd0,
        SCR_PLAY   = 2'd1,
        SCR_WAIT   = 2'd2,
        SCR_RESULT = 2'd3
    } screen_t;

    localparam int FONT_ADDR_W = 11;
    localparam int TURN_MAX    = 255;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector with configurable reset level
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            din_q <= RESET_VAL;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - frame-aligned title/play/wait/result sequencer and font ROM mux
// Optional wait-screen auto-advance: define SCREEN_SEQ_TIMEOUT_EN.
module screen_sequencer
    import poker_pkg::*;
#(
    parameter int WAIT_MIN_FRAMES     = 30,
    parameter int WAIT_TIMEOUT_FRAMES = 600,
    parameter int CNT_W               = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic                   btn_confirm,
    input  logic                   turn_done,
    input  logic                   game_over,
    input  logic [FONT_ADDR_W-1:0] font_addr_title,
    input  logic [FONT_ADDR_W-1:0] font_addr_play,
    input  logic [FONT_ADDR_W-1:0] font_addr_wait,
    input  logic [FONT_ADDR_W-1:0] font_addr_result,
    output logic [FONT_ADDR_W-1:0] font_address,
    output screen_t                screen_sel,
    output logic                   active_player,
    output logic [7:0]             turn_count,
    output logic                   screen_changed
);

`ifdef SCREEN_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] MIN_CNT     = CNT_W'(WAIT_MIN_FRAMES);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT_FRAMES);

    screen_t          state, state_next;
    logic             player_next;
    logic [7:0]       turns_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             btn_rise;
    logic             timeout_hit;

    // Button copy starts high so a press held through reset is not seen as an edge.
    rise_detect #(.RESET_VAL(1'b1)) u_btn_rise (
        .clk   (clk),
        .reset (reset),
        .din   (btn_confirm),
        .rise  (btn_rise)
    );

    assign timeout_hit = TIMEOUT_EN && (wait_cnt >= TIMEOUT_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= SCR_TITLE;
            active_player <= 1'b0;
            turn_count    <= 8'd0;
        end else begin
            state         <= state_next;
            active_player <= player_next;
            turn_count    <= turns_next;
        end
    end

    always_comb begin
        state_next  = state;
        player_next = active_player;
        turns_next  = turn_count;
        case (state)
            SCR_TITLE: begin
                if (btn_rise) begin
                    state_next  = SCR_PLAY;
                    player_next = 1'b0;
                    turns_next  = 8'd0;
                end
            end
            SCR_PLAY: begin
                if (turn_done) begin
                    if (game_over) begin
                        state_next = SCR_RESULT;
                    end else begin
                        state_next  = SCR_WAIT;
                        player_next = ~active_player;
                        if (turn_count != 8'(TURN_MAX)) begin
                            turns_next = turn_count + 8'd1;
                        end
                    end
                end
            end
            SCR_WAIT: begin
                // Early presses fall through here and are simply dropped.
                if ((btn_rise && (wait_cnt >= MIN_CNT)) || timeout_hit) begin
                    state_next = SCR_PLAY;
                end
            end
            SCR_RESULT: begin
                if (btn_rise) begin
                    state_next = SCR_TITLE;
                end
            end
            default: state_next = SCR_TITLE;
        endcase
    end

    // Display register: screens only change at vertical blank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            screen_sel     <= SCR_TITLE;
            screen_changed <= 1'b0;
        end else begin
            screen_changed <= frame_start && (state != screen_sel);
            if (frame_start) begin
                screen_sel <= state;
            end
        end
    end

    // Counts frames the wait screen has actually been on display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (screen_sel != SCR_WAIT) begin
            wait_cnt <= '0;
        end else if (frame_start && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        font_address = font_addr_title;
        case (screen_sel)
            SCR_TITLE:  font_address = font_addr_title;
            SCR_PLAY:   font_address = font_addr_play;
            SCR_WAIT:   font_address = font_addr_wait;
            SCR_RESULT: font_address = font_addr_result;
            default:    font_address = font_addr_title;
        endcase
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - randomized and directed self-checking bench for screen_sequencer
module tb_screen_sequencer;

    localparam int WMIN  = 30;
    localparam int WTO   = 600;
    localparam int FP    = 4;
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        btn = 1'b1;
    logic        td = 1'b0;
    logic        go = 1'b0;
    logic [10:0] fa_t = 11'd0, fa_p = 11'd0, fa_w = 11'd0, fa_r = 11'd0;
    logic [10:0] font_address;
    logic [1:0]  screen_sel;
    logic        active_player;
    logic [7:0]  turn_count;
    logic        screen_changed;

    int vectors = 0;
    int miscompares = 0;
    int ph = 0;
    bit hold_font = 1'b0;

    // Model: screens numbered 0 title, 1 play, 2 wait, 3 result.
    int m_state, m_screen, m_player, m_turns, m_wait, m_bprev;
    bit m_changed;

    always #5 clk = ~clk;

    screen_sequencer #(
        .WAIT_MIN_FRAMES(WMIN),
        .WAIT_TIMEOUT_FRAMES(WTO),
        .CNT_W(10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_start      (frame_start),
        .btn_confirm      (btn),
        .turn_done        (td),
        .game_over        (go),
        .font_addr_title  (fa_t),
        .font_addr_play   (fa_p),
        .font_addr_wait   (fa_w),
        .font_addr_result (fa_r),
        .font_address     (font_address),
        .screen_sel       (screen_sel),
        .active_player    (active_player),
        .turn_count       (turn_count),
        .screen_changed   (screen_changed)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_screen = 0; m_player = 0; m_turns = 0;
            m_wait = 0; m_bprev = 1; m_changed = 1'b0;
        end else begin
            int  ns, np, nt, nw, nscr;
            bit  rise;
            rise = btn && (m_bprev == 0);
            ns = m_state; np = m_player; nt = m_turns;
            if (m_state == 0 && rise) begin
                ns = 1; np = 0; nt = 0;
            end else if (m_state == 1 && td) begin
                if (go) ns = 3;
                else begin
                    ns = 2; np = 1 - m_player;
                    nt = (m_turns >= 255) ? 255 : m_turns + 1;
                end
            end else if (m_state == 2) begin
                if (rise && m_wait >= WMIN) ns = 1;
`ifdef SCREEN_SEQ_TIMEOUT_EN
                if (m_wait >= WTO) ns = 1;
`endif
            end else if (m_state == 3 && rise) begin
                ns = 0;
            end
            m_changed = frame_start && (m_state != m_screen);
            nscr = frame_start ? m_state : m_screen;
            if (m_screen != 2) nw = 0;
            else if (frame_start) nw = (m_wait >= 1023) ? 1023 : m_wait + 1;
            else nw = m_wait;
            m_state = ns; m_player = np; m_turns = nt;
            m_screen = nscr; m_wait = nw; m_bprev = btn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_font();
        case (m_screen)
            0: return fa_t;
            1: return fa_p;
            2: return fa_w;
            default: return fa_r;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("screen_sel", 32'(screen_sel), 32'(m_screen));
        chk("active_player", 32'(active_player), 32'(m_player));
        chk("turn_count", 32'(turn_count), 32'(m_turns));
        chk("screen_changed", 32'(screen_changed), 32'(m_changed));
        chk("font_address", 32'(font_address), 32'(exp_font()));
    end

    task automatic step();
        @(posedge clk);
        #2;
        frame_start = (ph == 0);
        ph = (ph + 1) % FP;
        if (!hold_font) begin
            fa_t = 11'($urandom); fa_p = 11'($urandom);
            fa_w = 11'($urandom); fa_r = 11'($urandom);
        end
    endtask

    task automatic press();
        btn = 1'b0; step();
        btn = 1'b1; step();
    endtask

    task automatic turn(input logic over);
        td = 1'b1; go = over; step();
        td = 1'b0; go = 1'b0; step();
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FP) step();
    endtask

    task automatic wait_cnt_reach(input int n);
        int lim = 0;
        while (m_wait < n && lim < LIMIT) begin
            step(); lim++;
        end
        if (lim >= LIMIT) begin
            vectors++; miscompares++;
            $display("FAIL wait_cnt_timeout: got %0d expected >= %0d", m_wait, n);
        end
    endtask

    initial begin
        reset = 1'b1; btn = 1'b1;
        repeat (3) step();
        chk("reset_screen", 32'(screen_sel), 32'd0);
        chk("reset_turns", 32'(turn_count), 32'd0);
        reset = 1'b0;
        repeat (10) step();
        chk("held_btn_title", 32'(screen_sel), 32'd0);
        press();
        wait_frames(2);
        chk("title_to_play", 32'(screen_sel), 32'd1);
        turn(1'b0);
        chk("first_turn_player", 32'(active_player), 32'd1);
        chk("first_turn_count", 32'(turn_count), 32'd1);
        wait_frames(2);
        chk("wait_shown", 32'(screen_sel), 32'd2);
        wait_cnt_reach(10);
        press();
        wait_frames(2);
        chk("early_press_ignored", 32'(screen_sel), 32'd2);
        wait_cnt_reach(WMIN);
        press();
        wait_frames(2);
        chk("wait_to_play", 32'(screen_sel), 32'd1);
        chk("player_kept", 32'(active_player), 32'd1);

        for (int i = 0; i < 256; i++) begin
            turn(1'b0);
            wait_cnt_reach(WMIN);
            press();
        end
        chk("turns_saturated", 32'(turn_count), 32'd255);
        turn(1'b1);
        wait_frames(2);
        chk("result_shown", 32'(screen_sel), 32'd3);
        press();
        wait_frames(2);
        chk("result_to_title", 32'(screen_sel), 32'd0);

        press();
        turn(1'b0);
`ifdef SCREEN_SEQ_TIMEOUT_EN
        wait_frames(WTO + 3);
        chk("timeout_to_play", 32'(screen_sel), 32'd1);
`else
        wait_frames(1000);
        chk("no_timeout_wait", 32'(screen_sel), 32'd2);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) btn = ~btn;
            td = ($urandom_range(0, 5) == 0);
            go = ($urandom_range(0, 3) == 0);
            step();
        end
        td = 1'b0; go = 1'b0; btn = 1'b1;

        reset = 1'b1; step();
        reset = 1'b0; step();
        press();
        wait_frames(2);
        turn(1'b0);
        wait_frames(2);
        chk("pre_reset_wait", 32'(screen_sel), 32'd2);
        hold_font = 1'b1;
        fa_w = 11'h410; fa_t = 11'h123;
        step();
        #1 reset = 1'b1;
        #1;
        chk("async_reset_screen", 32'(screen_sel), 32'd0);
        chk("async_reset_font", 32'(font_address), 32'h123);
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
